// File: rtl/fifo_ctrl_pkg.sv
// Shared definitions for the board-level FIFO sequencing controller:
// state encoding and state-vector width.
package fifo_ctrl_pkg;

    localparam int STATE_W = 2;

    // 2'b10 is deliberately unused; the controller treats it as a corrupted state.
    typedef enum logic [STATE_W-1:0] {
        ST_EMPTY  = 2'b00,
        ST_NORMAL = 2'b01,
        ST_FULL   = 2'b11
    } state_t;

endpackage

// File: rtl/edge_pulse.sv
// Rising-edge detector for a debounced button level. The history register
// powers up as "pressed" so a button held through reset never fires.
module edge_pulse (
    input  logic clk,
    input  logic clr,
    input  logic level_i,
    output logic pulse_o
);

    logic prev_q;

    // NOTE: sequential state uses non-blocking assignment so every register
    // samples pre-edge values and simulation order cannot change the result.
    always_ff @(posedge clk) begin
        if (clr) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= level_i;
        end
    end

    assign pulse_o = level_i & ~prev_q;

endmodule

// File: rtl/fifo_ctrl.sv
// FIFO sequencing controller: converts button presses into single write/read
// strobes, owns the pointers, occupancy count, EMPTY/NORMAL/FULL FSM and flags.
module fifo_ctrl
    import fifo_ctrl_pkg::*;
#(
    parameter int W = 2
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               wr_btn,
    input  logic               rd_btn,
    output logic               wr_en,
    output logic               re_en,
    output logic [W-1:0]       w_addr,
    output logic [W-1:0]       r_addr,
    output logic [W:0]         count,
    output logic               empty,
    output logic               full,
    output logic               ovf,
    output logic               unf,
    output logic [STATE_W-1:0] state
);

    localparam int         CW    = W + 1;
    localparam logic [W:0] DEPTH = {1'b1, {W{1'b0}}};

    logic wr_req;
    logic rd_req;

    edge_pulse u_wr_edge (
        .clk     (clk),
        .clr     (clr),
        .level_i (wr_btn),
        .pulse_o (wr_req)
    );

    edge_pulse u_rd_edge (
        .clk     (clk),
        .clr     (clr),
        .level_i (rd_btn),
        .pulse_o (rd_req)
    );

    state_t          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [W-1:0]    w_ptr_q, r_ptr_q;
    logic            wr_en_q, wr_en_d;
    logic            re_en_q, re_en_d;
    logic            ovf_q, ovf_d;
    logic            unf_q, unf_d;
    logic            empty_q, full_q;
    logic            recover;

    // NOTE: every always_comb output gets a default before the case so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        wr_en_d = 1'b0;
        re_en_d = 1'b0;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        recover = 1'b0;

        case (state_q)
            ST_EMPTY: begin
                wr_en_d = wr_req;
                if (rd_req) unf_d = 1'b1;
            end
            ST_NORMAL: begin
                wr_en_d = wr_req;
                re_en_d = rd_req;
            end
            ST_FULL: begin
                re_en_d = rd_req;
                if (wr_req) ovf_d = 1'b1;
            end
            default: recover = 1'b1;
        endcase

        count_d = count_q + CW'(wr_en_d) - CW'(re_en_d);

        if (count_d == '0) begin
            state_d = ST_EMPTY;
        end else if (count_d == DEPTH) begin
            state_d = ST_FULL;
        end else begin
            state_d = ST_NORMAL;
        end

        if (recover) begin
            state_d = ST_EMPTY;
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= ST_EMPTY;
            count_q <= '0;
            w_ptr_q <= '0;
            r_ptr_q <= '0;
            wr_en_q <= 1'b0;
            re_en_q <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            wr_en_q <= wr_en_d;
            re_en_q <= re_en_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            empty_q <= (count_d == '0);
            full_q  <= (count_d == DEPTH);
            // Pointers advance one edge after acceptance so the strobe cycle
            // presents the pre-increment address to the register file.
            if (recover) begin
                w_ptr_q <= '0;
                r_ptr_q <= '0;
            end else begin
                w_ptr_q <= w_ptr_q + W'(wr_en_q);
                r_ptr_q <= r_ptr_q + W'(re_en_q);
            end
        end
    end

    assign wr_en  = wr_en_q;
    assign re_en  = re_en_q;
    assign w_addr = w_ptr_q;
    assign r_addr = r_ptr_q;
    assign count  = count_q;
    assign empty  = empty_q;
    assign full   = full_q;
    assign ovf    = ovf_q;
    assign unf    = unf_q;
    assign state  = state_q;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl (W=2): directed scenarios plus random
// button traffic, all compared against a count-based reference model.
module tb_fifo_ctrl;

    localparam int W     = 2;
    localparam int DEPTH = 4;
    localparam logic [14:0] RST_VEC = {1'b0, 1'b0, 2'd0, 2'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00};

    logic         clk = 1'b0;
    logic         clr = 1'b1;
    logic         wr_btn = 1'b0;
    logic         rd_btn = 1'b0;
    logic         wr_en, re_en, empty, full, ovf, unf;
    logic [W-1:0] w_addr, r_addr;
    logic [W:0]   count;
    logic [1:0]   state;

    int n_tests = 0;
    int n_fail  = 0;

    fifo_ctrl #(.W(W)) dut (
        .clk    (clk),
        .clr    (clr),
        .wr_btn (wr_btn),
        .rd_btn (rd_btn),
        .wr_en  (wr_en),
        .re_en  (re_en),
        .w_addr (w_addr),
        .r_addr (r_addr),
        .count  (count),
        .empty  (empty),
        .full   (full),
        .ovf    (ovf),
        .unf    (unf),
        .state  (state)
    );

    always #5 clk = ~clk;

    // Reference model: occupancy plus running pointer positions.
    int m_count = 0, m_wptr = 0, m_rptr = 0;
    bit m_wr_en = 0, m_re_en = 0, m_ovf = 0, m_unf = 0;
    bit m_wprev = 1, m_rprev = 1;

    function automatic logic [14:0] dut_vec();
        return {wr_en, re_en, w_addr, r_addr, count, empty, full, ovf, unf, state};
    endfunction

    function automatic logic [14:0] exp_vec();
        logic [1:0] st;
        st = (m_count == 0) ? 2'b00 : (m_count == DEPTH) ? 2'b11 : 2'b01;
        return {m_wr_en, m_re_en, 2'(m_wptr), 2'(m_rptr), 3'(m_count),
                m_count == 0, m_count == DEPTH, m_ovf, m_unf, st};
    endfunction

    task automatic model_edge(input bit w, input bit r, input bit c);
        bit wreq, rreq, aw, ar;
        if (c) begin
            m_count = 0; m_wptr = 0; m_rptr = 0;
            m_wr_en = 0; m_re_en = 0; m_ovf = 0; m_unf = 0;
            m_wprev = 1; m_rprev = 1;
        end else begin
            wreq = w && !m_wprev;
            rreq = r && !m_rprev;
            m_wptr = (m_wptr + int'(m_wr_en)) % DEPTH;
            m_rptr = (m_rptr + int'(m_re_en)) % DEPTH;
            aw = wreq && (m_count < DEPTH);
            ar = rreq && (m_count > 0);
            if (wreq && !aw) m_ovf = 1;
            if (rreq && !ar) m_unf = 1;
            m_count = m_count + int'(aw) - int'(ar);
            m_wr_en = aw;
            m_re_en = ar;
            m_wprev = w;
            m_rprev = r;
        end
    endtask

    task automatic step(input bit w, input bit r);
        wr_btn = w;
        rd_btn = r;
        @(posedge clk);
        model_edge(w, r, clr);
        #1;
    endtask

    task automatic test_reset();
        clr = 1'b1;
        step(0, 0);
        step(0, 0);
        n_tests++;
        if (dut_vec() !== RST_VEC) begin
            n_fail++;
            $display("FAIL reset: got %b expected %b", dut_vec(), RST_VEC);
        end
        clr = 1'b0;
        step(0, 0);
        n_tests++;
        if (dut_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL reset_idle: got %b expected %b", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < DEPTH; i++) begin
            step(1, 0);
            n_tests++;
            if (wr_en !== 1'b1 || w_addr !== 2'(i) || dut_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL fill_strobe%0d: got wr_en=%b w_addr=%0d vec=%b expected wr_en=1 w_addr=%0d vec=%b",
                         i, wr_en, w_addr, dut_vec(), i, exp_vec());
            end
            step(0, 0);
        end
        n_tests++;
        if (count !== 3'd4 || full !== 1'b1 || state !== 2'b11 || w_addr !== 2'd0) begin
            n_fail++;
            $display("FAIL fill_done: got count=%0d full=%b state=%b w_addr=%0d expected 4 1 11 0",
                     count, full, state, w_addr);
        end
    endtask

    task automatic test_overflow();
        step(1, 0);
        n_tests++;
        if (wr_en !== 1'b0 || ovf !== 1'b1 || count !== 3'd4 || w_addr !== 2'd0) begin
            n_fail++;
            $display("FAIL overflow: got wr_en=%b ovf=%b count=%0d w_addr=%0d expected 0 1 4 0",
                     wr_en, ovf, count, w_addr);
        end
        step(0, 0);
    endtask

    task automatic test_drain();
        for (int i = 0; i < DEPTH; i++) begin
            step(0, 1);
            n_tests++;
            if (re_en !== 1'b1 || r_addr !== 2'(i) || dut_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL drain_strobe%0d: got re_en=%b r_addr=%0d vec=%b expected re_en=1 r_addr=%0d vec=%b",
                         i, re_en, r_addr, dut_vec(), i, exp_vec());
            end
            step(0, 0);
        end
        step(0, 1);
        n_tests++;
        if (re_en !== 1'b0 || unf !== 1'b1 || empty !== 1'b1 || state !== 2'b00 || count !== 3'd0) begin
            n_fail++;
            $display("FAIL underflow: got re_en=%b unf=%b empty=%b state=%b count=%0d expected 0 1 1 00 0",
                     re_en, unf, empty, state, count);
        end
        step(0, 0);
    endtask

    task automatic test_simultaneous();
        clr = 1'b1;
        step(0, 0);
        clr = 1'b0;
        step(0, 0);
        step(1, 1);
        n_tests++;
        if (wr_en !== 1'b1 || re_en !== 1'b0 || count !== 3'd1 || unf !== 1'b1) begin
            n_fail++;
            $display("FAIL simul_empty: got wr_en=%b re_en=%b count=%0d unf=%b expected 1 0 1 1",
                     wr_en, re_en, count, unf);
        end
        step(0, 0);
        step(1, 0);
        step(0, 0);
        step(1, 1);
        n_tests++;
        if (wr_en !== 1'b1 || re_en !== 1'b1 || count !== 3'd2 || state !== 2'b01) begin
            n_fail++;
            $display("FAIL simul_normal: got wr_en=%b re_en=%b count=%0d state=%b expected 1 1 2 01",
                     wr_en, re_en, count, state);
        end
        step(0, 0);
        step(1, 0);
        step(0, 0);
        step(1, 0);
        step(0, 0);
        n_tests++;
        if (count !== 3'd4 || ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL simul_prefull: got count=%0d ovf=%b expected 4 0", count, ovf);
        end
        // Read accepted from FULL frees one entry; the write is refused.
        step(1, 1);
        n_tests++;
        if (wr_en !== 1'b0 || re_en !== 1'b1 || count !== 3'd3 || ovf !== 1'b1 || dut_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL simul_full: got wr_en=%b re_en=%b count=%0d ovf=%b expected 0 1 3 1",
                     wr_en, re_en, count, ovf);
        end
        step(0, 0);
    endtask

    task automatic test_held_button();
        int pulses;
        clr = 1'b1;
        step(1, 0);
        step(1, 0);
        clr = 1'b0;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            step(1, 0);
            if (wr_en === 1'b1) pulses++;
        end
        n_tests++;
        if (pulses !== 0) begin
            n_fail++;
            $display("FAIL held_through_reset: got %0d strobes expected 0", pulses);
        end
        step(0, 0);
        pulses = 0;
        for (int i = 0; i < 50; i++) begin
            step(1, 0);
            if (wr_en === 1'b1) pulses++;
        end
        n_tests++;
        if (pulses !== 1) begin
            n_fail++;
            $display("FAIL held_press: got %0d strobes expected 1", pulses);
        end
        step(0, 0);
        step(1, 0);
        n_tests++;
        if (wr_en !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_clr_strobe: got wr_en=%b expected 1", wr_en);
        end
        clr = 1'b1;
        step(0, 0);
        n_tests++;
        if (dut_vec() !== RST_VEC) begin
            n_fail++;
            $display("FAIL clr_in_strobe: got %b expected %b", dut_vec(), RST_VEC);
        end
        clr = 1'b0;
        step(0, 0);
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        for (int i = 0; i < 400; i++) begin
            clr = ($urandom_range(0, 63) == 0);
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            n_tests++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++;
                errs++;
                if (errs <= 10)
                    $display("FAIL random_cycle%0d: got %b expected %b", i, dut_vec(), exp_vec());
            end
        end
        clr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow();
        test_drain();
        test_simultaneous();
        test_held_button();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
